// File: rtl/core_top_v4.sv
// Parametrised multi-cycle core: loadable IMEM, decoder, register file and ALU
// behind a FETCH/DECODE/EXEC/WB sequencer with HALT and a retired counter.
//
// state   | meaning
// IDLE    | after reset; waits for start, IMEM writable
// FETCH   | synchronous IMEM read at pc
// DECODE  | latch instruction fields and register operands
// EXEC    | ALU result and next pc; HALT parks here -> HALTED
// WB      | register write-back, pc update, retire
// HALTED  | HALT retired; IMEM writable, start reruns from pc 0
module core_top_v4 #(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int NUM_REGS   = 16,
  localparam int PW = $clog2(IMEM_DEPTH),
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            store_en,
  input  logic [PW-1:0]   store_address,
  input  logic [31:0]     store_data,
  input  logic            start,
  output logic [XLEN-1:0] alu_data_out,
  output logic            result_valid,
  output logic [3:0]      opcode,
  output logic [PW-1:0]   pc,
  output logic            busy,
  output logic            halted,
  output logic [31:0]     retired
);

  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;
  localparam logic [3:0] OP_LI   = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED
  } state_t;

  state_t state_q, state_d;

  logic [31:0]     imem [IMEM_DEPTH];
  logic [31:0]     mem_q;
  logic [XLEN-1:0] regs [NUM_REGS];

  logic [3:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic            sel_q;
  logic [XLEN-1:0] imm_q, a_q, rs2_q, res_q;
  logic [PW-1:0]   pc_q, npc_q;
  logic [31:0]     retired_q;

  logic            idle_like, writes_rd, taken;
  logic [AW-1:0]   rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, b_op, alu_res;
  logic [SW-1:0]   shamt;
  logic [PW-1:0]   next_pc;
  logic            unused_fields;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign writes_rd = (op_q <= OP_LI);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_FETCH;
      S_FETCH:          state_d = S_DECODE;
      S_DECODE:         state_d = S_EXEC;
      S_EXEC:           state_d = (op_q == OP_HALT) ? S_HALTED : S_WB;
      S_WB:             state_d = S_FETCH;
      default:          state_d = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy         = 1'b0;
    halted       = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      S_FETCH, S_DECODE, S_EXEC: busy = 1'b1;
      S_WB: begin
        busy         = 1'b1;
        result_valid = writes_rd;
      end
      S_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  // IMEM has no reset so a loaded program survives a core reset
  always_ff @(posedge clk) begin
    if (store_en && idle_like) imem[store_address] <= store_data;
    if (state_q == S_FETCH)    mem_q <= imem[pc_q];
  end

  assign rs1_idx = mem_q[18 +: AW];
  assign rs2_idx = mem_q[13 +: AW];
  assign rs1_val = (rs1_idx == '0) ? '0 : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 : regs[rs2_idx];
  assign unused_fields = ^mem_q[27:13];

  assign b_op  = sel_q ? rs2_q : imm_q;
  assign shamt = b_op[SW-1:0];

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_op;
      OP_SUB:  alu_res = a_q - b_op;
      OP_AND:  alu_res = a_q & b_op;
      OP_OR:   alu_res = a_q | b_op;
      OP_XOR:  alu_res = a_q ^ b_op;
      OP_SLL:  alu_res = a_q << shamt;
      OP_SRL:  alu_res = a_q >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a_q) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_op))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (a_q < b_op)};
      OP_LI:   alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

  // branches always compare rs1 with rs2, ignoring sel
  assign taken = (op_q == OP_JMP) ||
                 ((op_q == OP_BEQ) && (a_q == rs2_q)) ||
                 ((op_q == OP_BNE) && (a_q != rs2_q));
  assign next_pc = taken ? (pc_q + imm_q[PW-1:0]) : (pc_q + PW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      npc_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      sel_q     <= 1'b0;
      imm_q     <= '0;
      a_q       <= '0;
      rs2_q     <= '0;
      res_q     <= '0;
      retired_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_q      <= '0;
            retired_q <= '0;
          end
        end
        S_DECODE: begin
          op_q  <= mem_q[31:28];
          rd_q  <= mem_q[23 +: AW];
          sel_q <= mem_q[12];
          imm_q <= {{(XLEN-12){mem_q[11]}}, mem_q[11:0]};
          a_q   <= rs1_val;
          rs2_q <= rs2_val;
        end
        S_EXEC: begin
          if (op_q == OP_HALT) begin
            retired_q <= retired_q + 32'd1;
          end else begin
            npc_q <= next_pc;
            if (writes_rd) res_q <= alu_res;
          end
        end
        S_WB: begin
          if (writes_rd && (rd_q != '0)) regs[rd_q] <= res_q;
          pc_q      <= npc_q;
          retired_q <= retired_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign alu_data_out = res_q;
  assign opcode       = op_q;
  assign pc           = pc_q;
  assign retired      = retired_q;

endmodule

// File: doc/core_top_v4.md
# core_top_v4

Parametrised successor to the fixed-width single-issue core top. It integrates a loadable instruction memory, an instruction decoder, a register file and an ALU behind one explicit multi-cycle sequencer. XLEN, memory depth and register count are parameters. Adds branches, jumps, HALT, start/restart control and a retired-instruction counter. Sits at the top of the core; the store port is driven by the test harness or boot loader.

## Interface
- XLEN, 32: datapath width; legal 16..64.
- IMEM_DEPTH, 64: instruction words; power of 2, 4..1024. PW = $clog2(IMEM_DEPTH).
- NUM_REGS, 16: architectural registers; power of 2, 2..32. AW = $clog2(NUM_REGS).
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- store_en  in  1  instruction-memory write strobe.
- store_address  in  PW  write word address.
- store_data  in  32  instruction word.
- start  in  1  begin execution at pc 0.
- alu_data_out  out  XLEN  value written back by the current instruction.
- result_valid  out  1  one-cycle pulse qualifying alu_data_out.
- opcode  out  4  opcode of the instruction in flight.
- pc  out  PW  address of the instruction in flight.
- busy  out  1  high in FETCH/DECODE/EXEC/WB.
- halted  out  1  high in HALTED.
- retired  out  32  count of completed instructions; wraps.

## Operation
- Instruction format: [31:28] opcode, [27:23] rd, [22:18] rs1, [17:13] rs2, [12] sel (1 = rs2, 0 = imm), [11:0] imm, sign-extended to XLEN. Register fields use their low AW bits.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount = low $clog2(XLEN) bits of operand B.
  - 8 SLT (signed), 9 SLTU: result 1 or 0.
  - 10 LI: rd = imm.
  - 11 BEQ, 12 BNE: compare rs1 with rs2 regardless of sel.
  - 13 JMP.
  - 14 NOP.
  - 15 HALT.
- Operand A = rs1. Operand B = sel ? rs2 : imm. Arithmetic is modulo 2^XLEN.
- Register 0 reads as zero. Writes to register 0 are dropped, but result_valid still pulses with the computed value.
- Branch/JMP target = pc + imm, in word units, truncated to PW bits (wraps). Every other instruction advances pc + 1 modulo IMEM_DEPTH.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
  - IDLE or HALTED with start=1 → FETCH. This sets pc = 0 and retired = 0. Registers are retained.
  - FETCH → DECODE: synchronous IMEM read at pc.
  - DECODE → EXEC: latch the instruction, drive opcode, read rs1/rs2.
  - EXEC → WB: compute the ALU result and the next pc. If opcode is HALT: EXEC → HALTED and retired increments.
  - WB → FETCH: write rd for opcodes 0–10 and pulse result_valid. Update pc. Increment retired.
- start while busy is ignored.
- store_en is accepted only in IDLE or HALTED. It is ignored while busy. IMEM is not cleared by reset.
- Reset values:
  - State IDLE; pc, opcode and retired = 0.
  - alu_data_out = 0; result_valid, busy and halted = 0.
  - All registers = 0.

## Timing
- Four cycles per non-HALT instruction.
- With start sampled at edge 0, instruction i is in FETCH at cycle 4i+1, DECODE 4i+2, EXEC 4i+3 and WB 4i+4. result_valid is high during cycle 4i+4.
- A HALT at index i makes halted assert from cycle 4i+4.
- alu_data_out holds its value until the next write-back.
- Store write is visible to a fetch on the following cycle.
- store_en and start in the same IDLE cycle: both take effect. The write completes before the first fetch reads the array.
- Reset asserted mid-instruction: next cycle is IDLE with all reset values. No partial write-back occurs.

## Test plan
- Load LI r1,5; LI r2,7; ADD r3,r1,r2 (sel=1); HALT; pulse start → result_valid at cycles 4, 8, 12 with values 5, 7, 12; halted at 16; retired = 4.
- LI r1,-1; SRL r2,r1,imm 28 (XLEN=32) → 0x0000000F. SRA with the same operands → 0xFFFFFFFF. SLT r1 vs imm 0 → 1; SLTU → 0.
- BNE loop: LI r1,3; ADDI r1,r1,-1 (opcode 0, sel=0); BNE r1,r0,-1; HALT → 8 retirements; r1 = 0; halted.
- IMEM_DEPTH=4, JMP +3 at pc 2 → next pc 1 (wrap). Write-back to r0 → result_valid pulses, r0 still reads 0.
- store_en while busy → IMEM unchanged. Start while busy → ignored. Start from HALTED → rerun from pc 0 with retired reset to 0.
- Reset asserted at a WB cycle → rd not written; next cycle: IDLE, pc 0, busy 0, all registers zero.
